// File: rtl/interrupt_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : interrupt_controller_if                                          |
// | Brief   : Ex-stage memory bus snooped by the interrupt controller.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface interrupt_controller_if;
  logic [15:0] Aaddr;
  logic [1:0]  ExMemControl;
  logic [15:0] ExCalResult;
  logic [15:0] readData;
  logic        readHit;

  modport master (
    output Aaddr, ExMemControl, ExCalResult,
    input  readData, readHit
  );

  modport slave (
    input  Aaddr, ExMemControl, ExCalResult,
    output readData, readHit
  );
endinterface
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : interrupt_controller                                             |
// | Brief   : Edge-latched, maskable, fixed-priority interrupt dispatcher with  |
// |           memory-mapped mask/status registers. Optional periodic timer     |
// |           source enabled by INTERRUPT_CONTROLLER_TIMER_EN.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module interrupt_controller #(
  parameter int          NSRC        = 4,
  parameter logic [3:0]  INDEX_BASE  = 4'd8,
  parameter logic [15:0] MASK_ADDR   = 16'hBF10,
  parameter logic [15:0] STATUS_ADDR = 16'hBF11,
  parameter int          HOLDOFF     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NSRC-1:0]     irqIn,
  interrupt_controller_if.slave bus,
  output logic                hardwareInterruptSignal,
  output logic [3:0]          hardwareInterruptIndex
);

  localparam logic [1:0] c_MEM_READ  = 2'b01;
  localparam logic [1:0] c_MEM_WRITE = 2'b10;

`ifdef INTERRUPT_CONTROLLER_TIMER_EN
  localparam logic [15:0] c_TIMER_ADDR = 16'hBF12;
  localparam int          c_NBITS      = NSRC + 1;
`else
  localparam int          c_NBITS      = NSRC;
`endif
  // Implemented pending/mask bits; everything above reads 0 and ignores writes.
  localparam logic [15:0] c_VALID = 16'((17'h1 << c_NBITS) - 17'h1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_HOLD  = 2'd2
  } stateType;

  stateType          r_state;
  logic [NSRC-1:0]   r_sync1;
  logic [NSRC-1:0]   r_sync2;
  logic [NSRC-1:0]   r_syncPrev;
  logic [15:0]       r_pending;
  logic [15:0]       r_mask;
  logic [7:0]        r_holdCnt;
  logic              r_sig;
  logic [3:0]        r_idx;

  logic              w_wrMask;
  logic              w_wrStatus;
  logic              w_rd;
  logic [15:0]       w_setBits;
  logic [15:0]       w_eligible;
  logic              w_selFound;
  logic [3:0]        w_selNum;
  logic [15:0]       w_dispClr;
  logic [15:0]       w_w1cBits;

  assign w_wrMask   = (bus.ExMemControl == c_MEM_WRITE) && (bus.Aaddr == MASK_ADDR);
  assign w_wrStatus = (bus.ExMemControl == c_MEM_WRITE) && (bus.Aaddr == STATUS_ADDR);
  assign w_rd       = (bus.ExMemControl == c_MEM_READ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_syncPrev <= '0;
    end else begin
      r_sync1    <= irqIn;
      r_sync2    <= r_sync1;
      r_syncPrev <= r_sync2;
    end
  end

`ifdef INTERRUPT_CONTROLLER_TIMER_EN
  logic [15:0] r_period;
  logic [15:0] r_count;
  logic        w_wrTimer;
  logic        w_timerTick;

  assign w_wrTimer   = (bus.ExMemControl == c_MEM_WRITE) && (bus.Aaddr == c_TIMER_ADDR);
  assign w_timerTick = (r_period != 16'h0) && (r_count == 16'h1);

  // Reload on reaching 1 so a period of N yields a tick every N cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_period <= 16'h0;
      r_count  <= 16'h0;
    end else if (w_wrTimer) begin
      r_period <= bus.ExCalResult;
      r_count  <= bus.ExCalResult;
    end else if (r_period != 16'h0) begin
      r_count <= (r_count <= 16'h1) ? r_period : r_count - 16'h1;
    end
  end
`endif

  always_comb begin
    w_setBits = 16'(r_sync2 & ~r_syncPrev);
`ifdef INTERRUPT_CONTROLLER_TIMER_EN
    w_setBits[NSRC] = w_timerTick;
`endif
  end

  assign w_eligible = r_pending & ~r_mask;

  // Scan downwards so the lowest-numbered eligible source wins.
  always_comb begin
    w_selFound = 1'b0;
    w_selNum   = 4'h0;
    for (int i = 15; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_selFound = 1'b1;
        w_selNum   = 4'(i);
      end
    end
  end

  assign w_dispClr = ((r_state == S_IDLE) && w_selFound) ? (16'h1 << w_selNum) : 16'h0;
  assign w_w1cBits = w_wrStatus ? bus.ExCalResult : 16'h0;

  // New edges are OR-ed in last so they survive a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= 16'h0;
      r_mask    <= 16'h0;
    end else begin
      r_pending <= ((r_pending & ~w_dispClr & ~w_w1cBits) | w_setBits) & c_VALID;
      if (w_wrMask) begin
        r_mask <= bus.ExCalResult & c_VALID;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_sig     <= 1'b0;
      r_idx     <= 4'h0;
      r_holdCnt <= 8'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_selFound) begin
            r_sig   <= 1'b1;
            r_idx   <= INDEX_BASE + w_selNum;
            r_state <= S_PULSE;
          end
        end
        S_PULSE: begin
          r_sig     <= 1'b0;
          r_holdCnt <= 8'(HOLDOFF);
          r_state   <= S_HOLD;
        end
        S_HOLD: begin
          r_holdCnt <= r_holdCnt - 8'h1;
          if (r_holdCnt <= 8'h1) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_sig   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign hardwareInterruptSignal = r_sig;
  assign hardwareInterruptIndex  = r_idx;

  always_comb begin
    bus.readHit  = 1'b0;
    bus.readData = 16'h0;
    if (w_rd) begin
      if (bus.Aaddr == MASK_ADDR) begin
        bus.readHit  = 1'b1;
        bus.readData = r_mask;
      end else if (bus.Aaddr == STATUS_ADDR) begin
        bus.readHit  = 1'b1;
        bus.readData = r_pending;
      end
`ifdef INTERRUPT_CONTROLLER_TIMER_EN
      else if (bus.Aaddr == c_TIMER_ADDR) begin
        bus.readHit  = 1'b1;
        bus.readData = r_period;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_interrupt_controller                                          |
// | Brief   : Scoreboard bench: expected pulses (index, cycle) are queued when |
// |           stimulus is driven and matched against observed pulses.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_interrupt_controller;

  localparam logic [15:0] c_MASK_ADDR   = 16'hBF10;
  localparam logic [15:0] c_STATUS_ADDR = 16'hBF11;
  localparam logic [15:0] c_TIMER_ADDR  = 16'hBF12;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] cyc;
  } pulseType;

  logic       clk;
  logic       rst;
  logic [3:0] irqIn;
  logic       hardwareInterruptSignal;
  logic [3:0] hardwareInterruptIndex;
  int         cyc;
  int         nChecks;
  int         nFail;
  pulseType   expQ[$];
  pulseType   obsQ[$];

  interrupt_controller_if bus();

  interrupt_controller dut (
    .clk                     (clk),
    .rst                     (rst),
    .irqIn                   (irqIn),
    .bus                     (bus),
    .hardwareInterruptSignal (hardwareInterruptSignal),
    .hardwareInterruptIndex  (hardwareInterruptIndex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to the next falling edge and record any pulse seen there.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (hardwareInterruptSignal === 1'b1)
        obsQ.push_back({hardwareInterruptIndex, 32'(cyc)});
    end
  endtask

  task automatic busWrite(input logic [15:0] addr, input logic [15:0] data);
    bus.Aaddr        = addr;
    bus.ExCalResult  = data;
    bus.ExMemControl = 2'b10;
    step();
    bus.ExMemControl = 2'b00;
    bus.Aaddr        = 16'h0;
    bus.ExCalResult  = 16'h0;
  endtask

  task automatic busRead(input logic [15:0] addr, output logic [15:0] data, output logic hit);
    bus.Aaddr        = addr;
    bus.ExMemControl = 2'b01;
    #1;
    data             = bus.readData;
    hit              = bus.readHit;
    bus.ExMemControl = 2'b00;
    bus.Aaddr        = 16'h0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    logic        h;
    step(2);
    nChecks++;
    if (hardwareInterruptSignal !== 1'b0 || hardwareInterruptIndex !== 4'd0) begin
      nFail++;
      $display("FAIL reset_outputs: sig=%b idx=%0d, required sig=0 idx=0",
               hardwareInterruptSignal, hardwareInterruptIndex);
    end
    busRead(c_MASK_ADDR, d, h);
    nChecks++;
    if (d !== 16'h0 || h !== 1'b1) begin
      nFail++;
      $display("FAIL reset_mask: data=%h hit=%b, required 0000 hit=1", d, h);
    end
    busRead(16'h1234, d, h);
    nChecks++;
    if (d !== 16'h0 || h !== 1'b0) begin
      nFail++;
      $display("FAIL unmapped_read: data=%h hit=%b, required 0000 hit=0", d, h);
    end
    nChecks++;
    if (bus.readData !== 16'h0 || bus.readHit !== 1'b0) begin
      nFail++;
      $display("FAIL idle_bus: data=%h hit=%b, required 0000 hit=0", bus.readData, bus.readHit);
    end
    @(negedge clk);
    rst = 1'b1;
    step(3);
  endtask

  task automatic test_single_edge();
    logic [15:0] d;
    logic        h;
    pulseType    e;
    pulseType    o;
    expQ.push_back({4'd9, 32'(cyc + 4)});
    irqIn[1] = 1'b1;
    step();
    irqIn[1] = 1'b0;
    step(20);
    busRead(c_STATUS_ADDR, d, h);
    nChecks++;
    if (d !== 16'h0 || h !== 1'b1) begin
      nFail++;
      $display("FAIL single_status: data=%h hit=%b, required 0000 hit=1", d, h);
    end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      nChecks++;
      if (obsQ.size() == 0) begin
        nFail++;
        $display("FAIL single_pulse: missing pulse, required idx=%0d cyc=%0d", e.idx, e.cyc);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin
          nFail++;
          $display("FAIL single_pulse: idx=%0d cyc=%0d, required idx=%0d cyc=%0d", o.idx, o.cyc, e.idx, e.cyc);
        end
      end
    end
    nChecks++;
    if (obsQ.size() != 0) begin
      nFail++;
      $display("FAIL single_extra: %0d extra pulses, required 0", obsQ.size());
      obsQ.delete();
    end
  endtask

  task automatic test_simultaneous();
    pulseType e;
    pulseType o;
    expQ.push_back({4'd8, 32'(cyc + 4)});
    expQ.push_back({4'd10, 32'(cyc + 14)});
    irqIn = 4'b0101;
    step(30);
    irqIn = 4'b0000;
    step(4);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      nChecks++;
      if (obsQ.size() == 0) begin
        nFail++;
        $display("FAIL simul_pulse: missing pulse, required idx=%0d cyc=%0d", e.idx, e.cyc);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin
          nFail++;
          $display("FAIL simul_pulse: idx=%0d cyc=%0d, required idx=%0d cyc=%0d", o.idx, o.cyc, e.idx, e.cyc);
        end
      end
    end
    nChecks++;
    if (obsQ.size() != 0) begin
      nFail++;
      $display("FAIL simul_extra: %0d extra pulses, required 0", obsQ.size());
      obsQ.delete();
    end
  endtask

  task automatic test_mask();
    logic [15:0] d;
    logic        h;
    pulseType    e;
    pulseType    o;
    busWrite(c_MASK_ADDR, 16'hFFF1);
    busRead(c_MASK_ADDR, d, h);
    nChecks++;
    if (d !== 16'h0001 || h !== 1'b1) begin
      nFail++;
      $display("FAIL mask_readback: data=%h hit=%b, required 0001 hit=1", d, h);
    end
    irqIn[0] = 1'b1;
    step(20);
    irqIn[0] = 1'b0;
    busRead(c_STATUS_ADDR, d, h);
    nChecks++;
    if (d !== 16'h0001) begin
      nFail++;
      $display("FAIL mask_status: data=%h, required 0001", d);
    end
    expQ.push_back({4'd8, 32'(cyc + 2)});
    busWrite(c_MASK_ADDR, 16'h0000);
    step(15);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      nChecks++;
      if (obsQ.size() == 0) begin
        nFail++;
        $display("FAIL mask_pulse: missing pulse, required idx=%0d cyc=%0d", e.idx, e.cyc);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin
          nFail++;
          $display("FAIL mask_pulse: idx=%0d cyc=%0d, required idx=%0d cyc=%0d", o.idx, o.cyc, e.idx, e.cyc);
        end
      end
    end
    nChecks++;
    if (obsQ.size() != 0) begin
      nFail++;
      $display("FAIL mask_extra: %0d extra pulses, required 0", obsQ.size());
      obsQ.delete();
    end
  endtask

  task automatic test_w1c();
    logic [15:0] d;
    logic        h;
    pulseType    e;
    pulseType    o;
    busWrite(c_MASK_ADDR, 16'h0008);
    irqIn[3] = 1'b1;
    step(5);
    busRead(c_STATUS_ADDR, d, h);
    nChecks++;
    if (d !== 16'h0008) begin
      nFail++;
      $display("FAIL w1c_before: data=%h, required 0008", d);
    end
    busWrite(c_STATUS_ADDR, 16'h0008);
    step(3);
    busRead(c_STATUS_ADDR, d, h);
    nChecks++;
    if (d !== 16'h0000) begin
      nFail++;
      $display("FAIL w1c_after: data=%h, required 0000", d);
    end
    irqIn[3] = 1'b0;
    step(3);
    busWrite(c_MASK_ADDR, 16'h0000);
    step(15);
    busWrite(c_MASK_ADDR, 16'h0008);
    // Edge reaches pending on the same clock as the W1C write.
    irqIn[3] = 1'b1;
    step(2);
    busWrite(c_STATUS_ADDR, 16'h0008);
    busRead(c_STATUS_ADDR, d, h);
    nChecks++;
    if (d !== 16'h0008) begin
      nFail++;
      $display("FAIL w1c_edge_same_cycle: data=%h, required 0008", d);
    end
    expQ.push_back({4'd11, 32'(cyc + 2)});
    busWrite(c_MASK_ADDR, 16'h0000);
    step(15);
    irqIn[3] = 1'b0;
    step(3);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      nChecks++;
      if (obsQ.size() == 0) begin
        nFail++;
        $display("FAIL w1c_pulse: missing pulse, required idx=%0d cyc=%0d", e.idx, e.cyc);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin
          nFail++;
          $display("FAIL w1c_pulse: idx=%0d cyc=%0d, required idx=%0d cyc=%0d", o.idx, o.cyc, e.idx, e.cyc);
        end
      end
    end
    nChecks++;
    if (obsQ.size() != 0) begin
      nFail++;
      $display("FAIL w1c_extra: %0d extra pulses, required 0", obsQ.size());
      obsQ.delete();
    end
  endtask

  task automatic test_reset_hold();
    logic [15:0] d;
    logic        h;
    pulseType    e;
    pulseType    o;
    busWrite(c_MASK_ADDR, 16'h0002);
    expQ.push_back({4'd8, 32'(cyc + 4)});
    irqIn = 4'b0101;
    step(7);
    #2 rst = 1'b0;
    #1;
    nChecks++;
    if (hardwareInterruptSignal !== 1'b0) begin
      nFail++;
      $display("FAIL hold_reset_sig: sig=%b, required 0", hardwareInterruptSignal);
    end
    busRead(c_MASK_ADDR, d, h);
    nChecks++;
    if (d !== 16'h0) begin
      nFail++;
      $display("FAIL hold_reset_mask: data=%h, required 0000", d);
    end
    busRead(c_STATUS_ADDR, d, h);
    nChecks++;
    if (d !== 16'h0) begin
      nFail++;
      $display("FAIL hold_reset_pending: data=%h, required 0000", d);
    end
    irqIn = 4'b0000;
    step(2);
    rst = 1'b1;
    step(20);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      nChecks++;
      if (obsQ.size() == 0) begin
        nFail++;
        $display("FAIL hold_pulse: missing pulse, required idx=%0d cyc=%0d", e.idx, e.cyc);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin
          nFail++;
          $display("FAIL hold_pulse: idx=%0d cyc=%0d, required idx=%0d cyc=%0d", o.idx, o.cyc, e.idx, e.cyc);
        end
      end
    end
    nChecks++;
    if (obsQ.size() != 0) begin
      nFail++;
      $display("FAIL hold_extra: %0d extra pulses, required 0", obsQ.size());
      obsQ.delete();
    end
  endtask

  task automatic test_reset_pulse();
    pulseType e;
    pulseType o;
    expQ.push_back({4'd9, 32'(cyc + 4)});
    irqIn[1] = 1'b1;
    step();
    irqIn[1] = 1'b0;
    step(3);
    #2 rst = 1'b0;
    #1;
    nChecks++;
    if (hardwareInterruptSignal !== 1'b0 || hardwareInterruptIndex !== 4'd0) begin
      nFail++;
      $display("FAIL pulse_reset: sig=%b idx=%0d, required sig=0 idx=0",
               hardwareInterruptSignal, hardwareInterruptIndex);
    end
    nChecks++;
    if (bus.readData !== 16'h0 || bus.readHit !== 1'b0) begin
      nFail++;
      $display("FAIL pulse_reset_read: data=%h hit=%b, required 0000 hit=0", bus.readData, bus.readHit);
    end
    step(2);
    rst = 1'b1;
    step(15);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      nChecks++;
      if (obsQ.size() == 0) begin
        nFail++;
        $display("FAIL rp_pulse: missing pulse, required idx=%0d cyc=%0d", e.idx, e.cyc);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin
          nFail++;
          $display("FAIL rp_pulse: idx=%0d cyc=%0d, required idx=%0d cyc=%0d", o.idx, o.cyc, e.idx, e.cyc);
        end
      end
    end
    nChecks++;
    if (obsQ.size() != 0) begin
      nFail++;
      $display("FAIL rp_extra: %0d extra pulses, required 0", obsQ.size());
      obsQ.delete();
    end
  endtask

`ifdef INTERRUPT_CONTROLLER_TIMER_EN
  task automatic test_timer();
    logic [15:0] d;
    logic        h;
    int          c0;
    pulseType    e;
    pulseType    o;
    busWrite(c_MASK_ADDR, 16'h0010);
    c0 = cyc;
    busWrite(c_TIMER_ADDR, 16'd5);
    busRead(c_TIMER_ADDR, d, h);
    nChecks++;
    if (d !== 16'd5 || h !== 1'b1) begin
      nFail++;
      $display("FAIL timer_readback: data=%h hit=%b, required 0005 hit=1", d, h);
    end
    step(4);
    busRead(c_STATUS_ADDR, d, h);
    nChecks++;
    if (d !== 16'h0000) begin
      nFail++;
      $display("FAIL timer_before_tick: data=%h, required 0000", d);
    end
    step();
    busRead(c_STATUS_ADDR, d, h);
    nChecks++;
    if (d !== 16'h0010) begin
      nFail++;
      $display("FAIL timer_tick1: data=%h, required 0010", d);
    end
    step();
    busWrite(c_STATUS_ADDR, 16'h0010);
    step(2);
    busRead(c_STATUS_ADDR, d, h);
    nChecks++;
    if (d !== 16'h0000) begin
      nFail++;
      $display("FAIL timer_cleared: data=%h, required 0000", d);
    end
    step();
    busRead(c_STATUS_ADDR, d, h);
    nChecks++;
    if (d !== 16'h0010) begin
      nFail++;
      $display("FAIL timer_tick2: data=%h, required 0010", d);
    end
    expQ.push_back({4'd12, 32'(c0 + 13)});
    expQ.push_back({4'd12, 32'(c0 + 23)});
    busWrite(c_MASK_ADDR, 16'h0000);
    step(12);
    busWrite(c_TIMER_ADDR, 16'd0);
    step(30);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      nChecks++;
      if (obsQ.size() == 0) begin
        nFail++;
        $display("FAIL timer_pulse: missing pulse, required idx=%0d cyc=%0d", e.idx, e.cyc);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin
          nFail++;
          $display("FAIL timer_pulse: idx=%0d cyc=%0d, required idx=%0d cyc=%0d", o.idx, o.cyc, e.idx, e.cyc);
        end
      end
    end
    nChecks++;
    if (obsQ.size() != 0) begin
      nFail++;
      $display("FAIL timer_extra: %0d extra pulses, required 0", obsQ.size());
      obsQ.delete();
    end
  endtask
`else
  task automatic test_timer_unmapped();
    logic [15:0] d;
    logic        h;
    busRead(c_TIMER_ADDR, d, h);
    nChecks++;
    if (d !== 16'h0 || h !== 1'b0) begin
      nFail++;
      $display("FAIL timer_unmapped: data=%h hit=%b, required 0000 hit=0", d, h);
    end
    busWrite(c_MASK_ADDR, 16'hFFFF);
    busRead(c_MASK_ADDR, d, h);
    nChecks++;
    if (d !== 16'h000F) begin
      nFail++;
      $display("FAIL mask_width: data=%h, required 000f", d);
    end
    busWrite(c_MASK_ADDR, 16'h0000);
  endtask
`endif

  initial begin
    nChecks          = 0;
    nFail            = 0;
    rst              = 1'b0;
    irqIn            = 4'b0000;
    bus.Aaddr        = 16'h0;
    bus.ExMemControl = 2'b00;
    bus.ExCalResult  = 16'h0;
    test_reset();
    test_single_edge();
    test_simultaneous();
    test_mask();
    test_w1c();
    test_reset_hold();
    test_reset_pulse();
`ifdef INTERRUPT_CONTROLLER_TIMER_EN
    test_timer();
`else
    test_timer_unmapped();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Collects asynchronous peripheral interrupt requests, latches them as pending, and applies a software-writable mask. Arbitrates by fixed priority and drives the CPU's hardwareInterruptSignal/hardwareInterruptIndex inputs with a one-cycle request pulse, followed by a programmable holdoff. Sits directly upstream of the CPU interrupt arbitration. Snoops the CPU's Ex-stage memory bus (Aaddr, ExMemControl, ExCalResult) for memory-mapped mask, status and timer registers.

Parameters:
NSRC, 4, number of external interrupt sources (1..8)
INDEX_BASE, 4'd8, index reported for source 0; source n reports (INDEX_BASE+n) mod 16
MASK_ADDR, 16'hBF10, mask register address (write/read)
STATUS_ADDR, 16'hBF11, pending register address (read; write-1-to-clear)
HOLDOFF, 8, idle cycles after each pulse before the next dispatch (1..255)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active low
irqIn  input  NSRC  raw peripheral requests; asynchronous, level, rising-edge significant
Aaddr  input  16  CPU data address
ExMemControl  input  2  2'b00 idle, 2'b01 read, 2'b10 write, 2'b11 treated as idle
ExCalResult  input  16  CPU write data
readData  output  16  register read data
readHit  output  1  high when a read addresses one of this block's registers
hardwareInterruptSignal  output  1  one-cycle interrupt request to the CPU
hardwareInterruptIndex  output  4  interrupt index, valid while the signal is high

Behaviour:
- Reset is asynchronous: all flops clear immediately on rst=0, including synchronisers, pending, FSM and counters. mask=16'h0000 (all sources enabled). Outputs: hardwareInterruptSignal=0, hardwareInterruptIndex=0, readData=0, readHit=0.
- Input path: each irqIn bit passes through a 2-flop synchroniser and then a rising-edge detector. A detected edge sets pending[n]. Total latency from an irqIn rise to a pending bit set is 3 clk.
- Bits pending[15:NSRC] and mask[15:NSRC] read as 0 and ignore writes. When the timer is compiled in, bit NSRC is the exception.
- Dispatch FSM:
  - IDLE: if (pending & ~mask) != 0, select the lowest-numbered set bit n, clear pending[n], go to PULSE.
  - PULSE (1 cycle): hardwareInterruptSignal=1, hardwareInterruptIndex=INDEX_BASE+n. Load the holdoff counter with HOLDOFF. Go to HOLD.
  - HOLD: decrement the counter each cycle; at 0 go to IDLE. Minimum spacing between pulses is HOLDOFF+2 cycles.
- The index output holds its last value outside PULSE.
- Masked pending bits remain pending. Unmasking them later makes them eligible for dispatch.
- Register writes (ExMemControl=2'b10) take effect at the clock edge:
  - MASK_ADDR loads the mask.
  - STATUS_ADDR clears the pending bits where the data bit is 1.
- Register reads (ExMemControl=2'b01) are combinational: readHit=1 and readData=register value, the same cycle. Otherwise readHit=0 and readData=0.
- Simultaneous events in one cycle:
  - New edge and dispatch-clear on the same bit: set wins (bit stays pending).
  - New edge and W1C on the same bit: set wins.
  - Mask write while in IDLE: this cycle's selection uses the old mask.
- One edge produces exactly one dispatch. A level held high does not re-request.
- Reset asserted in PULSE or HOLD: the FSM returns to IDLE and the signal drops immediately.

Optional Feature:
INTERRUPT_CONTROLLER_TIMER_EN
- With the macro: adds a 16-bit periodic timer as source NSRC, with lowest priority.
  - TIMER_ADDR=16'hBF12 is the period register, reset value 0. Period 0 disables the timer.
  - Writing the period reloads the down-counter. At count 1 the timer sets pending[NSRC] and reloads, so the period is exactly N cycles.
  - The timer reads back its period at TIMER_ADDR.
- Without the macro: no timer logic. TIMER_ADDR is unmapped (readHit=0), and pending/mask bit NSRC behaves like any unused bit.

Test Plan:
- Reset, then pulse irqIn[1] high for 1 cycle (shortened HOLDOFF not used; HOLDOFF=8) -> exactly one signal pulse, 4 cycles after the rising edge, with index 4'd9. Status read then returns 16'h0000.
- Raise irqIn[0] and irqIn[2] in the same cycle -> index 8 pulse, then index 10 pulse exactly 10 cycles later.
- Write 16'h0001 to MASK_ADDR, then raise irqIn[0] -> no pulse, and status read = 16'h0001. Write 16'h0000 to the mask -> index 8 pulse in the following cycle.
- With irqIn[3] pending and masked, write 16'h0008 to STATUS_ADDR -> status=0. Unmasking produces no pulse. An edge in the same cycle as the W1C write keeps the bit set.
- Drop rst mid-HOLD, and separately in the PULSE cycle -> signal=0 immediately, and pending, mask and readData are 0.
- With TIMER_EN, write 16'd5 to 16'hBF12 -> pending[4] sets every 5 cycles, and index 12 pulses when no higher-priority source is pending. Write 0 -> pulses stop.
